immediate_formatter: RTL and testbench
======================================

IMMEDIATE_FORMATTER -- requirements
Module: immediate_formatter

Interface
REQ-001 SHALL have parameter UPPERCASE, default 1: hex letters are emitted as "A"-"F" when 1 and as "a"-"f" when 0.
REQ-002 SHALL have port clk_in, input, 1: single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_in, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start_in, input, 1: request to format value_in; sampled only in IDLE.
REQ-005 SHALL have port value_in, input, 32: immediate to format, latched on an accepted start.
REQ-006 SHALL have port term_in, input, 8: terminator character (" " or ","), latched on an accepted start.
REQ-007 SHALL have port out_ascii, output, 8: current output character.
REQ-008 SHALL have port out_valid, output, 1: out_ascii holds a valid character.
REQ-009 SHALL have port out_ready, input, 1: the consumer accepts the character; a transfer occurs when out_valid && out_ready.
REQ-010 SHALL have port busy_flag, output, 1: high whenever state != IDLE.
REQ-011 SHALL have port done_flag, output, 1: one-cycle pulse after the terminator transfers.

Function
REQ-012 SHALL implement states IDLE, PREFIX, DIGITS, TERM, DONE.
REQ-013 IDLE: start_in=1 SHALL latch value_in, term_in and the digit count N, then move to PREFIX on the next edge.
REQ-014 N SHALL be the smallest value in 1..8 such that sign-extending bit 4N-1 of the low 4N bits reproduces value_in exactly. This makes the output round-trip through the team's immediate parser, which sign-extends the first digit.
REQ-015 PREFIX: SHALL drive out_ascii="x" with out_valid=1, and move to DIGITS on transfer.
REQ-016 DIGITS: SHALL emit nibbles N-1 down to 0, most significant first, one per transfer; after nibble 0 transfers, SHALL move to TERM.
REQ-017 TERM: SHALL drive the latched terminator, and move to DONE on transfer.
REQ-018 DONE: SHALL assert done_flag for exactly one cycle with out_valid=0, then return to IDLE.
REQ-019 Latency: start accepted in cycle k SHALL give out_valid=1 with "x" in cycle k+1.
REQ-020 While out_valid && !out_ready, out_ascii and the state SHALL hold stable.
REQ-021 out_valid SHALL be 0 in IDLE and DONE, and 1 in PREFIX, DIGITS and TERM.
REQ-022 start_in outside IDLE, including in DONE, SHALL be ignored; the latched operands SHALL NOT change.
REQ-023 The earliest new start SHALL be accepted in the cycle after DONE, i.e. when the state is IDLE.
REQ-024 out_ascii SHALL be 8'h00 whenever out_valid=0.
REQ-025 The total character count per operation SHALL be N+2.

Reset
REQ-026 rst_in=1 at any edge, including mid-stream, SHALL force IDLE, out_valid=0, done_flag=0, busy_flag=0, out_ascii=8'h00, latched value=0, latched terminator=0 and digit index=0.
REQ-027 A start_in asserted in the same cycle as rst_in SHALL be discarded.
REQ-028 A stream aborted by reset SHALL NOT be resumed; no terminator and no done_flag pulse SHALL follow.

Structure
REQ-029 The state typedef and a hex_to_ascii(nibble, upper) function SHALL live in package assembler_constants, alongside the existing ascii_to_hex, isAlpha and isNum helpers.
REQ-030 The digit-count computation SHALL be a combinational sub-module named min_hex_digits (32-bit input, 4-bit count output, range 1..8).
REQ-031 The remaining logic SHALL stay in a single always_ff block plus combinational output decode; no other sub-modules.

Verification
REQ-032 Scenario: value 32'h0000001F, term " ", out_ready=1 -> stream "x","1","F"," ", then done_flag for 1 cycle; 4 transfers total.
REQ-033 Scenario: value 32'h0000000F, term "," -> stream "x","0","F",","; the leading 0 is required because the digit F has its MSB set.
REQ-034 Scenario: sign-extension values, each checked separately: 32'hFFFFFFFF -> "xF"+term; 32'hFFFFFFF0 -> "xF0"+term; 32'h00000000 -> "x0"+term; 32'h80000000 -> "x80000000"+term.
REQ-035 Scenario: value 32'h12345678 with out_ready toggling 1,0,0,1,... -> out_ascii stable during every stall; stream "x12345678"+term; no characters duplicated or dropped.
REQ-036 Scenario: rst_in pulsed after the 3rd transfer of 32'hABCDEF01 -> out_valid=0 the next cycle, busy_flag=0, no done_flag pulse; a fresh start of 32'h7 then yields "x7"+term.
REQ-037 Scenario: start_in held high continuously across two operations -> the second operation starts only in the cycle after done_flag; start pulses during busy states change nothing.

Source files
------------

// File: rtl/assembler_constants_pkg.sv
// Shared assembler constants: formatter state encoding and ASCII/hex helpers.
package assembler_constants;

  localparam int unsigned VALUE_W = 32;
  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned COUNT_W = 4;
  localparam int unsigned INDEX_W = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PREFIX = 3'd1,
    DIGITS = 3'd2,
    TERM   = 3'd3,
    DONE   = 3'd4
  } fmt_state_t;

  localparam logic [CHAR_W-1:0] CHAR_X   = 8'h78;
  localparam logic [CHAR_W-1:0] CHAR_NUL = 8'h00;

  // Nibble to ASCII hex digit, letter case selected by upper.
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib, input logic upper);
    if (nib < 4'd10) return 8'h30 + 8'(nib);
    return (upper ? 8'h41 : 8'h61) + 8'(nib) - 8'd10;
  endfunction

  function automatic logic isNum(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic isAlpha(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

  // ASCII hex digit to nibble; non-hex characters map to zero.
  function automatic logic [3:0] ascii_to_hex(input logic [7:0] c);
    if (isNum(c)) return 4'(c - 8'h30);
    if ((c >= 8'h41) && (c <= 8'h46)) return 4'(c - 8'h41 + 8'd10);
    if ((c >= 8'h61) && (c <= 8'h66)) return 4'(c - 8'h61 + 8'd10);
    return 4'd0;
  endfunction

endpackage

// File: rtl/min_hex_digits.sv
// Smallest hex digit count whose sign-extended top digit reproduces the value.
module min_hex_digits
  import assembler_constants::*;
(
  input  logic [VALUE_W-1:0] value,
  output logic [COUNT_W-1:0] count
);

  // True when bits [31:4n-1] are all equal, i.e. n digits sign-extend back to value.
  function automatic logic sign_run(input logic [VALUE_W-1:0] v, input int n);
    logic signed [VALUE_W-1:0] hi;
    hi = $signed(v) >>> (4 * n - 1);
    return (hi == 32'sd0) || (hi == -32'sd1);
  endfunction

  // Scan downward so the last hit is the smallest qualifying count.
  always_comb begin
    count = 4'd8;
    for (int i = 7; i >= 1; i--) begin
      if (sign_run(value, i)) count = 4'(i);
    end
  end

endmodule

// File: rtl/immediate_formatter.sv
// Streams a 32-bit immediate as "x" + minimal sign-extending hex digits + terminator.
module immediate_formatter
  import assembler_constants::*;
#(
  parameter bit UPPERCASE = 1'b1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic [VALUE_W-1:0] value_in,
  input  logic [CHAR_W-1:0]  term_in,
  output logic [CHAR_W-1:0]  out_ascii,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy_flag,
  output logic               done_flag
);

  fmt_state_t           state;
  logic [VALUE_W-1:0]   value_q;
  logic [CHAR_W-1:0]    term_q;
  logic [INDEX_W-1:0]   idx;
  logic [COUNT_W-1:0]   digit_count;
  logic                 xfer;

  min_hex_digits u_min_hex_digits (
    .value (value_in),
    .count (digit_count)
  );

  assign xfer = out_valid && out_ready;

  // Nibble at position n of the latched value.
  function automatic logic [3:0] nibble(input logic [VALUE_W-1:0] v, input logic [INDEX_W-1:0] n);
    return v[{n, 2'b00} +: 4];
  endfunction

  // State machine with registered character, valid, busy and done outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      value_q   <= '0;
      term_q    <= '0;
      idx       <= '0;
      out_ascii <= CHAR_NUL;
      out_valid <= 1'b0;
      busy_flag <= 1'b0;
      done_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_flag <= 1'b0;
          if (start_in) begin
            value_q   <= value_in;
            term_q    <= term_in;
            idx       <= INDEX_W'(digit_count - 4'd1);
            out_ascii <= CHAR_X;
            out_valid <= 1'b1;
            busy_flag <= 1'b1;
            state     <= PREFIX;
          end
        end
        PREFIX: begin
          if (xfer) begin
            out_ascii <= hex_to_ascii(nibble(value_q, idx), UPPERCASE);
            state     <= DIGITS;
          end
        end
        DIGITS: begin
          if (xfer) begin
            if (idx == '0) begin
              out_ascii <= term_q;
              state     <= TERM;
            end else begin
              idx       <= idx - 3'd1;
              out_ascii <= hex_to_ascii(nibble(value_q, idx - 3'd1), UPPERCASE);
            end
          end
        end
        TERM: begin
          if (xfer) begin
            out_ascii <= CHAR_NUL;
            out_valid <= 1'b0;
            done_flag <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done_flag <= 1'b0;
          busy_flag <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          out_ascii <= CHAR_NUL;
          out_valid <= 1'b0;
          busy_flag <= 1'b0;
          done_flag <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_immediate_formatter.sv
// Directed bench for immediate_formatter: vector table plus stall, reset and back-to-back sequences.
module tb_immediate_formatter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic [31:0] value_in;
  logic [7:0]  term_in;
  logic [7:0]  out_ascii;
  logic        out_valid;
  logic        out_ready;
  logic        busy_flag;
  logic        done_flag;

  int checks = 0;
  int errors = 0;

  immediate_formatter #(.UPPERCASE(1'b1)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .start_in  (start_in),
    .value_in  (value_in),
    .term_in   (term_in),
    .out_ascii (out_ascii),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy_flag (busy_flag),
    .done_flag (done_flag)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] value;
    logic [7:0]  term;
    logic [79:0] exp;
    int          len;
    bit          toggle;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered at the falling edge of the cycle after start acceptance; follows the
  // stream to done_flag and the following idle cycle.
  task automatic expect_stream(input logic [79:0] exp, input int len, input bit toggle,
                               input string name);
    int  n = 0;
    int  cyc = 0;
    bit  stalled = 0;
    bit  finished = 0;
    logic [7:0] held = 8'h00;
    logic [7:0] want;
    logic rdy;
    chk({name, " first valid"}, 32'(out_valid), 32'd1);
    for (int t = 0; t < 200 && !finished; t++) begin
      rdy = !toggle || (cyc % 3 == 0);
      out_ready = rdy;
      if (done_flag) begin
        chk({name, " count"}, 32'(n), 32'(len));
        chk({name, " done valid"}, 32'(out_valid), 32'd0);
        chk({name, " done ascii"}, 32'(out_ascii), 32'd0);
        chk({name, " done busy"}, 32'(busy_flag), 32'd1);
        finished = 1;
      end else if (out_valid) begin
        if (stalled) chk({name, " stall hold"}, 32'(out_ascii), 32'(held));
        if (rdy) begin
          want = (n < len) ? exp[8*(len-1-n) +: 8] : 8'hEE;
          chk({name, " char"}, 32'(out_ascii), 32'(want));
          n++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = out_ascii;
        end
        chk({name, " busy"}, 32'(busy_flag), 32'd1);
        cyc++;
      end else begin
        chk({name, " idle ascii"}, 32'(out_ascii), 32'd0);
      end
      @(negedge clk_in);
    end
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout: got no done_flag expected done within 200 cycles", name);
    end
    out_ready = 1'b1;
    chk({name, " done pulse width"}, 32'(done_flag), 32'd0);
    chk({name, " idle busy"}, 32'(busy_flag), 32'd0);
    chk({name, " idle valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_op(input logic [31:0] v, input logic [7:0] term, input logic [79:0] exp,
                        input int len, input bit toggle, input string name);
    @(negedge clk_in);
    start_in = 1'b1;
    value_in = v;
    term_in  = term;
    @(negedge clk_in);
    start_in = 1'b0;
    value_in = 32'hDEAD_BEEF;
    chk({name, " prefix"}, 32'(out_ascii), 32'h78);
    expect_stream(exp, len, toggle, name);
  endtask

  initial begin
    int n;
    vecs[0] = '{32'h0000001F, " ", "x1F ",       4,  1'b0};
    vecs[1] = '{32'h0000000F, ",", "x0F,",       4,  1'b0};
    vecs[2] = '{32'hFFFFFFFF, " ", "xF ",        3,  1'b0};
    vecs[3] = '{32'hFFFFFFF0, ",", "xF0,",       4,  1'b0};
    vecs[4] = '{32'h00000000, " ", "x0 ",        3,  1'b0};
    vecs[5] = '{32'h80000000, " ", "x80000000 ", 10, 1'b0};
    vecs[6] = '{32'h12345678, ",", "x12345678,", 10, 1'b1};
    vecs[7] = '{32'h000007FF, " ", "x7FF ",      5,  1'b0};
    vecs[8] = '{32'hFFFFF800, ",", "x800,",      5,  1'b1};
    vecs[9] = '{32'h00000008, " ", "x08 ",       4,  1'b1};

    rst_in    = 1'b1;
    start_in  = 1'b1;
    value_in  = 32'h1234_5678;
    term_in   = " ";
    out_ready = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("reset valid", 32'(out_valid), 32'd0);
    chk("reset ascii", 32'(out_ascii), 32'd0);
    chk("reset busy",  32'(busy_flag), 32'd0);
    chk("reset done",  32'(done_flag), 32'd0);
    start_in = 1'b0;
    rst_in   = 1'b0;
    @(negedge clk_in);
    chk("start under reset discarded", 32'(busy_flag), 32'd0);

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].value, vecs[i].term, vecs[i].exp, vecs[i].len, vecs[i].toggle,
             $sformatf("vec%0d", i));

    // Reset after the third transfer aborts the stream with no done pulse.
    @(negedge clk_in);
    start_in = 1'b1;
    value_in = 32'hABCDEF01;
    term_in  = " ";
    out_ready = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    n = 0;
    for (int t = 0; t < 20 && n < 3; t++) begin
      if (out_valid) n++;
      @(negedge clk_in);
    end
    chk("abort transfers", 32'(n), 32'd3);
    chk("abort pre-reset ascii", 32'(out_ascii), 32'h43);
    rst_in   = 1'b1;
    start_in = 1'b1;
    @(negedge clk_in);
    rst_in   = 1'b0;
    start_in = 1'b0;
    chk("abort valid", 32'(out_valid), 32'd0);
    chk("abort busy",  32'(busy_flag), 32'd0);
    chk("abort ascii", 32'(out_ascii), 32'd0);
    n = 0;
    repeat (6) begin
      if (done_flag || out_valid || busy_flag) n++;
      @(negedge clk_in);
    end
    chk("abort no resume", 32'(n), 32'd0);
    run_op(32'h00000007, " ", "x7 ", 3, 1'b0, "after abort");

    // start held high across two operations; mid-op operand changes are ignored.
    @(negedge clk_in);
    start_in = 1'b1;
    value_in = 32'h0000001F;
    term_in  = " ";
    @(negedge clk_in);
    value_in = 32'h00000005;
    term_in  = ",";
    chk("b2b prefix", 32'(out_ascii), 32'h78);
    expect_stream("x1F ", 4, 1'b0, "b2b first");
    @(negedge clk_in);
    start_in = 1'b0;
    chk("b2b second prefix", 32'(out_ascii), 32'h78);
    expect_stream("x5,", 3, 1'b0, "b2b second");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
